// File: rtl/msk_hpc2o_tof_feeder.sv
// Issue/retire controller around an HPC2 AND-XOR gadget (out = a&b ^ c, latency 2).
// Optional macro MSK_FEEDER_CLR_EN zeroes every gadget input on bubble cycles.
module msk_hpc2o_tof_feeder #(
    parameter int d          = 2,
    parameter int FIFO_DEPTH = 4,
    localparam int hpc2rnd   = d * (d - 1) / 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [d-1:0]       in_a,
    input  logic [d-1:0]       in_b,
    input  logic [d-1:0]       in_c,
    input  logic               rnd_valid,
    output logic               rnd_ready,
    input  logic [hpc2rnd-1:0] rnd_in,
    output logic [d-1:0]       g_inb,
    output logic [hpc2rnd-1:0] g_rnd,
    output logic [d-1:0]       g_ina,
    output logic [d-1:0]       g_inc,
    output logic [d-1:0]       g_inb_prev,
    input  logic [d-1:0]       g_out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [d-1:0]       out_data
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_IDX = PW'(FIFO_DEPTH - 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_occ;
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [d-1:0]  r_mem [FIFO_DEPTH];
    logic [d-1:0]  r_a;
    logic [d-1:0]  r_b;
    logic [d-1:0]  r_c;
    logic          r_v1;
    logic          r_v2;

    logic          w_creditOk;
    logic          w_fire;
    logic          w_push;
    logic          w_pop;

    // The credit counter covers the two gadget stages, so the FIFO can never overflow.
    assign w_creditOk = (r_cnt < DEPTH_C);
    assign w_fire     = in_valid & rnd_valid & w_creditOk;
    assign in_ready   = rnd_valid & w_creditOk;
    assign rnd_ready  = in_valid & w_creditOk;

    assign w_push     = r_v2;
    assign out_valid  = (r_occ != '0);
    assign w_pop      = out_valid & out_ready;
    assign out_data   = r_mem[r_rdPtr];

`ifdef MSK_FEEDER_CLR_EN
    assign g_inb = w_fire ? in_b : '0;
    assign g_rnd = w_fire ? rnd_in : '0;
`else
    assign g_inb = in_b;
    assign g_rnd = rnd_in;
`endif

    assign g_ina      = r_a;
    assign g_inc      = r_c;
    assign g_inb_prev = r_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a <= '0;
            r_b <= '0;
            r_c <= '0;
        end else if (w_fire) begin
            r_a <= in_a;
            r_b <= in_b;
            r_c <= in_c;
        end
`ifdef MSK_FEEDER_CLR_EN
        else begin
            r_a <= '0;
            r_b <= '0;
            r_c <= '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else begin
            r_v1 <= w_fire;
            r_v2 <= r_v1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            case ({w_fire, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= g_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_occ   <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= (r_wrPtr == LAST_IDX) ? '0 : r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= (r_rdPtr == LAST_IDX) ? '0 : r_rdPtr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule

// File: tb/tb_msk_hpc2o_tof_feeder.sv
// Self-checking bench for msk_hpc2o_tof_feeder with a behavioural HPC2 gadget and a queue-based
// reference model of issued operations (unmasked results and the cycle they become visible).
module tb_msk_hpc2o_tof_feeder;

    localparam int D     = 2;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_a;
    logic [1:0] in_b;
    logic [1:0] in_c;
    logic       rnd_valid;
    logic       rnd_ready;
    logic [0:0] rnd_in;
    logic [1:0] g_inb;
    logic [0:0] g_rnd;
    logic [1:0] g_ina;
    logic [1:0] g_inc;
    logic [1:0] g_inb_prev;
    logic [1:0] g_out;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_data;

    int nTests = 0;
    int nFail  = 0;

    typedef struct {
        bit res;
        int vis;
    } ent_t;

    ent_t q[$];
    int   cyc = 0;

    always #5 clk = ~clk;

    msk_hpc2o_tof_feeder #(.d(D), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd_in(rnd_in),
        .g_inb(g_inb), .g_rnd(g_rnd), .g_ina(g_ina), .g_inc(g_inc),
        .g_inb_prev(g_inb_prev), .g_out(g_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    // Behavioural gadget: b/rnd at t, a/c/b_prev at t+1, result shares valid at t+2.
    logic [0:0] gRndD;
    always @(posedge clk) begin
        gRndD <= g_rnd;
        g_out <= {((g_ina[0] ^ g_ina[1]) & (g_inb_prev[0] ^ g_inb_prev[1]))
                  ^ (g_inc[0] ^ g_inc[1]) ^ gRndD[0], gRndD[0]};
    end

    function automatic logic [1:0] rnd2();
        return 2'($urandom_range(0, 3));
    endfunction

    function automatic bit expOutValid();
        return (q.size() > 0) && (q[0].vis <= cyc);
    endfunction

    function automatic bit expCredit();
        return q.size() < DEPTH;
    endfunction

    // Inputs change mid-cycle; outputs are then observed 1 ns later.
    task automatic applyStimulus(input logic iv, input logic rv, input logic orr,
                                 input logic [1:0] a, input logic [1:0] b,
                                 input logic [1:0] c, input logic r);
        @(negedge clk);
        in_valid  = iv;
        rnd_valid = rv;
        out_ready = orr;
        in_a      = a;
        in_b      = b;
        in_c      = c;
        rnd_in    = r;
        #1;
    endtask

    // Advances one clock and updates the reference model from the driven inputs.
    task automatic advance();
        bit   fire;
        bit   pop;
        ent_t e;
        fire  = in_valid && rnd_valid && expCredit();
        pop   = expOutValid() && out_ready;
        e.res = ((in_a[0] ^ in_a[1]) & (in_b[0] ^ in_b[1])) ^ (in_c[0] ^ in_c[1]);
        e.vis = cyc + 3;
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (fire) q.push_back(e);
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        applyStimulus(0, 1, 1, rnd2(), rnd2(), rnd2(), 1'b0);
        nTests++;
        if (out_valid !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        nTests++;
        if (in_ready !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        @(posedge clk);
        rst_n = 1'b1;
        q.delete();
        applyStimulus(0, 1, 1, rnd2(), rnd2(), rnd2(), 1'b0);
        advance();
    endtask

    task automatic test_single();
        applyStimulus(1, 1, 1, 2'b10, 2'b11, 2'b01, 1'b1);
        nTests++;
        if (in_ready !== 1'b1 || rnd_ready !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL single_ready_t got=%b%b exp=11", in_ready, rnd_ready);
        end
        nTests++;
        if (g_inb !== 2'b11 || g_rnd !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL single_stage0 got=%b/%b exp=11/1", g_inb, g_rnd);
        end
        advance();
        applyStimulus(0, 1, 1, rnd2(), rnd2(), rnd2(), 1'($urandom));
        nTests++;
        if (rnd_ready !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL single_rnd_ready_t1 got=%b exp=0", rnd_ready);
        end
        nTests++;
        if (g_ina !== 2'b10 || g_inc !== 2'b01 || g_inb_prev !== 2'b11) begin
            nFail++;
            $display("[TB] FAIL single_stage1 got=%b/%b/%b exp=10/01/11", g_ina, g_inc, g_inb_prev);
        end
        advance();
        for (int k = 2; k < 6; k++) begin
            applyStimulus(0, 1, 1, rnd2(), rnd2(), rnd2(), 1'($urandom));
            nTests++;
            if (out_valid !== (k == 3)) begin
                nFail++;
                $display("[TB] FAIL single_out_valid_t%0d got=%b exp=%b", k, out_valid, (k == 3));
            end
            if (k == 3) begin
                nTests++;
                if ((out_data[0] ^ out_data[1]) !== 1'b1) begin
                    nFail++;
                    $display("[TB] FAIL single_result got=%b exp=1", out_data[0] ^ out_data[1]);
                end
            end
            advance();
        end
    endtask

    task automatic test_back_to_back();
        int pops = 0;
        for (int k = 0; k < 14; k++) begin
            logic iv;
            bit   ov;
            iv = (k < 8);
            applyStimulus(iv, 1, 1, rnd2(), rnd2(), rnd2(), 1'($urandom));
            ov = expOutValid();
            if (iv) begin
                nTests++;
                if (in_ready !== 1'b1) begin
                    nFail++;
                    $display("[TB] FAIL b2b_in_ready k=%0d got=%b exp=1", k, in_ready);
                end
            end
            nTests++;
            if (out_valid !== ov) begin
                nFail++;
                $display("[TB] FAIL b2b_out_valid k=%0d got=%b exp=%b", k, out_valid, ov);
            end
            if (ov) begin
                pops++;
                nTests++;
                if ((out_data[0] ^ out_data[1]) !== q[0].res) begin
                    nFail++;
                    $display("[TB] FAIL b2b_data k=%0d got=%b exp=%b", k, out_data[0] ^ out_data[1], q[0].res);
                end
            end
            advance();
        end
        nTests++;
        if (pops != 8) begin
            nFail++;
            $display("[TB] FAIL b2b_pop_count got=%0d exp=8", pops);
        end
    endtask

    task automatic test_backpressure();
        int acc  = 0;
        int pops = 0;
        for (int k = 0; k < 8; k++) begin
            bit ov;
            applyStimulus(1, 1, 0, rnd2(), rnd2(), rnd2(), 1'($urandom));
            ov = expOutValid();
            nTests++;
            if (in_ready !== (k < DEPTH)) begin
                nFail++;
                $display("[TB] FAIL bp_in_ready k=%0d got=%b exp=%b", k, in_ready, (k < DEPTH));
            end
            if (in_ready === 1'b1) acc++;
            nTests++;
            if (out_valid !== ov) begin
                nFail++;
                $display("[TB] FAIL bp_out_valid k=%0d got=%b exp=%b", k, out_valid, ov);
            end
            if (ov) begin
                nTests++;
                if ((out_data[0] ^ out_data[1]) !== q[0].res) begin
                    nFail++;
                    $display("[TB] FAIL bp_hold_data k=%0d got=%b exp=%b", k, out_data[0] ^ out_data[1], q[0].res);
                end
            end
            advance();
        end
        nTests++;
        if (acc != DEPTH) begin
            nFail++;
            $display("[TB] FAIL bp_accepted got=%0d exp=%0d", acc, DEPTH);
        end
        for (int k = 0; k < 6; k++) begin
            bit ov;
            applyStimulus(0, 1, 1, rnd2(), rnd2(), rnd2(), 1'($urandom));
            ov = expOutValid();
            nTests++;
            if (in_ready !== (k != 0)) begin
                nFail++;
                $display("[TB] FAIL bp_drain_in_ready k=%0d got=%b exp=%b", k, in_ready, (k != 0));
            end
            if (ov) begin
                pops++;
                nTests++;
                if ((out_data[0] ^ out_data[1]) !== q[0].res) begin
                    nFail++;
                    $display("[TB] FAIL bp_drain_data k=%0d got=%b exp=%b", k, out_data[0] ^ out_data[1], q[0].res);
                end
            end
            advance();
        end
        nTests++;
        if (pops != DEPTH) begin
            nFail++;
            $display("[TB] FAIL bp_pop_count got=%0d exp=%0d", pops, DEPTH);
        end
    endtask

    task automatic test_rnd_toggle();
        int fires = 0;
        for (int k = 0; k < 13; k++) begin
            logic iv;
            logic rv;
            bit   ov;
            bit   cr;
            iv = (k < 8);
            rv = (k % 2 == 0);
            applyStimulus(iv, rv, 1, rnd2(), rnd2(), rnd2(), 1'($urandom));
            ov = expOutValid();
            cr = expCredit();
            nTests++;
            if (in_ready !== (rv & cr) || rnd_ready !== (iv & cr)) begin
                nFail++;
                $display("[TB] FAIL rt_ready k=%0d got=%b%b exp=%b%b", k, in_ready, rnd_ready, rv & cr, iv & cr);
            end
            if (iv && rv && cr) fires++;
            nTests++;
            if (out_valid !== ov) begin
                nFail++;
                $display("[TB] FAIL rt_out_valid k=%0d got=%b exp=%b", k, out_valid, ov);
            end
            if (ov) begin
                nTests++;
                if ((out_data[0] ^ out_data[1]) !== q[0].res) begin
                    nFail++;
                    $display("[TB] FAIL rt_data k=%0d got=%b exp=%b", k, out_data[0] ^ out_data[1], q[0].res);
                end
            end
            advance();
        end
        nTests++;
        if (fires != 4 || q.size() != 0) begin
            nFail++;
            $display("[TB] FAIL rt_fire_count got=%0d/%0d exp=4/0", fires, q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] c;
        bit         res;
        applyStimulus(1, 1, 1, rnd2(), rnd2(), rnd2(), 1'($urandom));
        advance();
        applyStimulus(0, 1, 1, rnd2(), rnd2(), rnd2(), 1'($urandom));
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        q.delete();
        advance();
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 1, 1, rnd2(), rnd2(), rnd2(), 1'($urandom));
            nTests++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                nFail++;
                $display("[TB] FAIL rst_mid_idle k=%0d got=%b%b exp=01", k, out_valid, in_ready);
            end
            advance();
        end
        a   = rnd2();
        b   = rnd2();
        c   = rnd2();
        res = ((a[0] ^ a[1]) & (b[0] ^ b[1])) ^ (c[0] ^ c[1]);
        applyStimulus(1, 1, 1, a, b, c, 1'($urandom));
        advance();
        for (int k = 1; k < 5; k++) begin
            applyStimulus(0, 1, 1, rnd2(), rnd2(), rnd2(), 1'($urandom));
            nTests++;
            if (out_valid !== (k == 3)) begin
                nFail++;
                $display("[TB] FAIL rst_mid_out_valid k=%0d got=%b exp=%b", k, out_valid, (k == 3));
            end
            if (k == 3) begin
                nTests++;
                if ((out_data[0] ^ out_data[1]) !== res) begin
                    nFail++;
                    $display("[TB] FAIL rst_mid_data got=%b exp=%b", out_data[0] ^ out_data[1], res);
                end
            end
            advance();
        end
    endtask

    task automatic test_idle_inputs();
        applyStimulus(1, 1, 1, 2'b10, 2'b01, 2'b11, 1'b0);
        advance();
        applyStimulus(0, 1, 1, 2'b01, 2'b11, 2'b10, 1'b1);
        nTests++;
        if (g_ina !== 2'b10 || g_inc !== 2'b11 || g_inb_prev !== 2'b01) begin
            nFail++;
            $display("[TB] FAIL idle_stage1 got=%b/%b/%b exp=10/11/01", g_ina, g_inc, g_inb_prev);
        end
`ifdef MSK_FEEDER_CLR_EN
        nTests++;
        if (g_inb !== 2'b00 || g_rnd !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL idle_clear_stage0 got=%b/%b exp=00/0", g_inb, g_rnd);
        end
        advance();
        applyStimulus(0, 1, 1, 2'b01, 2'b11, 2'b10, 1'b1);
        nTests++;
        if (g_ina !== 2'b00 || g_inc !== 2'b00 || g_inb_prev !== 2'b00) begin
            nFail++;
            $display("[TB] FAIL idle_clear_stage1 got=%b/%b/%b exp=00/00/00", g_ina, g_inc, g_inb_prev);
        end
`else
        nTests++;
        if (g_inb !== 2'b11 || g_rnd !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL idle_pass_stage0 got=%b/%b exp=11/1", g_inb, g_rnd);
        end
        advance();
        applyStimulus(0, 1, 1, 2'b01, 2'b11, 2'b10, 1'b1);
        nTests++;
        if (g_ina !== 2'b10 || g_inc !== 2'b11 || g_inb_prev !== 2'b01) begin
            nFail++;
            $display("[TB] FAIL idle_hold_stage1 got=%b/%b/%b exp=10/11/01", g_ina, g_inc, g_inb_prev);
        end
`endif
        advance();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 1, 1, rnd2(), rnd2(), rnd2(), 1'($urandom));
            advance();
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        rnd_valid = 1'b0;
        out_ready = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_c      = '0;
        rnd_in    = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_rnd_toggle();
        test_reset_mid();
        test_idle_inputs();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
